// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for Rsa256Core: loads n, d and a MSB-first over ready/valid,
// kicks the core, then returns the low OUT_BYTES result bytes MSB-first. The key is retained.
module rsa_stream_ctrl #(
  parameter int KEY_BYTES = 32,
  parameter int OUT_BYTES = 31,
  parameter int W         = 8 * KEY_BYTES
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic         o_rx_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_core_start,
  output logic [W-1:0] o_core_a,
  output logic [W-1:0] o_core_d,
  output logic [W-1:0] o_core_n,
  input  logic [W-1:0] i_core_result,
  input  logic         i_core_finished,
  output logic         o_busy
);

  localparam int OW = 8 * OUT_BYTES;
  localparam int CW = $clog2(KEY_BYTES + 1);
  localparam logic [CW-1:0] LAST_KEY = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(OUT_BYTES - 1);

  typedef enum logic [2:0] {
    S_LOAD_N,
    S_LOAD_D,
    S_LOAD_A,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   n_q, n_d;
  logic [W-1:0]   d_q, d_d;
  logic [W-1:0]   a_q, a_d;
  logic [OW-1:0]  out_q, out_d;
  logic           rx_fire;
  logic           tx_fire;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_LOAD_N;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      a_q     <= a_d;
      out_q   <= out_d;
    end
  end

  assign rx_fire = i_rx_valid && o_rx_ready;
  assign tx_fire = o_tx_valid && i_tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    a_d     = a_q;
    out_d   = out_q;
    case (state_q)
      S_LOAD_N, S_LOAD_D, S_LOAD_A: begin
        if (rx_fire) begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == S_LOAD_N) n_d = {n_q[W-9:0], i_rx_data};
          if (state_q == S_LOAD_D) d_d = {d_q[W-9:0], i_rx_data};
          if (state_q == S_LOAD_A) a_d = {a_q[W-9:0], i_rx_data};
          if (cnt_q == LAST_KEY) begin
            cnt_d = '0;
            case (state_q)
              S_LOAD_N: state_d = S_LOAD_D;
              S_LOAD_D: state_d = S_LOAD_A;
              default:  state_d = S_START;
            endcase
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_core_finished) begin
          out_d   = i_core_result[OW-1:0];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_fire) begin
          out_d = {out_q[OW-9:0], 8'h00};
          cnt_d = cnt_q + CW'(1);
          // Last byte returns to ciphertext loading; n and d stay resident.
          if (cnt_q == LAST_OUT) begin
            cnt_d   = '0;
            state_d = S_LOAD_A;
          end
        end
      end
      default: state_d = S_LOAD_N;
    endcase
  end

  always_comb begin
    o_rx_ready   = 1'b0;
    o_tx_valid   = 1'b0;
    o_core_start = 1'b0;
    o_busy       = 1'b0;
    case (state_q)
      S_LOAD_N, S_LOAD_D, S_LOAD_A: o_rx_ready = 1'b1;
      S_START: begin
        o_core_start = 1'b1;
        o_busy       = 1'b1;
      end
      S_WAIT:  o_busy = 1'b1;
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_busy     = 1'b1;
      end
      default: o_busy = 1'b0;
    endcase
  end

  assign o_tx_data = out_q[OW-1 -: 8];
  assign o_core_a  = a_q;
  assign o_core_d  = d_q;
  assign o_core_n  = n_q;

  generate
    if (OW < W) begin : g_unused_result
      logic unused_result_bits;
      assign unused_result_bits = ^i_core_result[W-1:OW];
    end
  endgenerate

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Self-checking bench for rsa_stream_ctrl: a transaction-level model (byte shifts and a tx
// queue) is compared with the DUT every cycle, plus literal checks for the directed scenarios.
module tb_rsa_stream_ctrl;

  localparam logic [255:0] N_LIT = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
  localparam logic [255:0] D_LIT = 256'hB6ACE0B14720169839B15FD13326CF1A1829BEAFC37BB937BEC8802FBCF46BD9;

  localparam int P_LOAD_N = 0;
  localparam int P_LOAD_D = 1;
  localparam int P_LOAD_A = 2;
  localparam int P_START  = 3;
  localparam int P_WAIT   = 4;
  localparam int P_SEND   = 5;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [7:0]   i_rx_data = 8'h00;
  logic         i_rx_valid = 1'b0;
  logic         o_rx_ready;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready = 1'b0;
  logic         o_core_start;
  logic [255:0] o_core_a;
  logic [255:0] o_core_d;
  logic [255:0] o_core_n;
  logic [255:0] i_core_result = '0;
  logic         i_core_finished = 1'b0;
  logic         o_busy;

  int n_checks = 0;
  int n_fail = 0;
  bit checks_on = 1'b0;

  // Reference model state
  int           m_phase = P_LOAD_N;
  int           m_cnt = 0;
  logic [255:0] m_n = '0;
  logic [255:0] m_d = '0;
  logic [255:0] m_a = '0;
  logic [7:0]   m_txq[$];

  rsa_stream_ctrl dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .o_rx_ready      (o_rx_ready),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready),
    .o_core_start    (o_core_start),
    .o_core_a        (o_core_a),
    .o_core_d        (o_core_d),
    .o_core_n        (o_core_n),
    .i_core_result   (i_core_result),
    .i_core_finished (i_core_finished),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: operands accumulate by shift-and-or, result bytes go into a queue.
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_phase = P_LOAD_N;
      m_cnt   = 0;
      m_n     = '0;
      m_d     = '0;
      m_a     = '0;
      m_txq.delete();
    end else begin
      case (m_phase)
        P_LOAD_N, P_LOAD_D, P_LOAD_A: begin
          if (i_rx_valid) begin
            if (m_phase == P_LOAD_N) m_n = (m_n << 8) | 256'(i_rx_data);
            else if (m_phase == P_LOAD_D) m_d = (m_d << 8) | 256'(i_rx_data);
            else m_a = (m_a << 8) | 256'(i_rx_data);
            m_cnt++;
            if (m_cnt == 32) begin
              m_cnt = 0;
              m_phase++;
            end
          end
        end
        P_START: m_phase = P_WAIT;
        P_WAIT: begin
          if (i_core_finished) begin
            for (int k = 0; k < 31; k++) m_txq.push_back(i_core_result[8*(30-k) +: 8]);
            m_phase = P_SEND;
          end
        end
        default: begin
          if (i_tx_ready) begin
            void'(m_txq.pop_front());
            if (m_txq.size() == 0) m_phase = P_LOAD_A;
          end
        end
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (checks_on) begin
      chk("cmp_rx_ready", 256'(o_rx_ready), 256'(m_phase <= P_LOAD_A));
      chk("cmp_tx_valid", 256'(o_tx_valid), 256'(m_phase == P_SEND));
      chk("cmp_core_start", 256'(o_core_start), 256'(m_phase == P_START));
      chk("cmp_busy", 256'(o_busy), 256'(m_phase >= P_START));
      chk("cmp_tx_data", 256'(o_tx_data),
          256'((m_phase == P_SEND && m_txq.size() > 0) ? m_txq[0] : 8'h00));
      chk("cmp_core_n", o_core_n, m_n);
      chk("cmp_core_d", o_core_d, m_d);
      chk("cmp_core_a", o_core_a, m_a);
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit must_ready);
    int waited = 0;
    if (gaps) begin
      int k = $urandom_range(0, 2);
      repeat (k) begin
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
        @(posedge i_clk); #1;
      end
    end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    while (!o_rx_ready && waited < 300) begin
      waited++;
      @(negedge i_clk);
    end
    if (must_ready) chk("rx_ready_during_key", 256'(waited), 256'(0));
    if (!o_rx_ready) chk("rx_ready_timeout", 256'(o_rx_ready), 256'(1));
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [255:0] v, input bit gaps, input bit must_ready);
    for (int i = 0; i < 32; i++) send_byte(v[255-8*i -: 8], gaps, must_ready);
  endtask

  // Called right after the last a byte: the start pulse must be in this cycle only.
  task automatic check_start(input logic [255:0] a_exp);
    @(negedge i_clk);
    chk("start_pulse", 256'(o_core_start), 256'(1));
    chk("start_busy", 256'(o_busy), 256'(1));
    chk("start_rx_ready", 256'(o_rx_ready), 256'(0));
    chk("start_core_a", o_core_a, a_exp);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("start_single", 256'(o_core_start), 256'(0));
    chk("wait_busy", 256'(o_busy), 256'(1));
    chk("wait_rx_ready", 256'(o_rx_ready), 256'(0));
    @(posedge i_clk); #1;
  endtask

  task automatic finish_core(input logic [255:0] res, input int latency);
    i_core_result = res;
    repeat (latency) begin
      @(posedge i_clk); #1;
    end
    i_core_finished = 1'b1;
    @(posedge i_clk); #1;
    i_core_finished = 1'b0;
  endtask

  task automatic receive_bytes(input int mode, input logic [255:0] res, input string tag,
                               output logic [7:0] first_b, output logic [7:0] last_b);
    logic [7:0] got[$];
    int cyc = 0;
    while (got.size() < 31 && cyc < 3000) begin
      case (mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = (cyc % 3 == 0);
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge i_clk);
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
      @(posedge i_clk); #1;
      cyc++;
    end
    i_tx_ready = 1'b0;
    chk({tag, "_count"}, 256'(got.size()), 256'(31));
    for (int j = 0; j < got.size(); j++) chk({tag, "_byte"}, 256'(got[j]), 256'(res[247-8*j -: 8]));
    first_b = (got.size() > 0) ? got[0] : 8'h00;
    last_b  = (got.size() > 0) ? got[got.size()-1] : 8'h00;
    @(negedge i_clk);
    chk({tag, "_rx_ready_after"}, 256'(o_rx_ready), 256'(1));
    @(posedge i_clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] r_lit;
    logic [255:0] a_vec;
    logic [255:0] res;
    logic [7:0]   fb, lb;
    bit           saw_tx;

    r_lit = '0;
    r_lit[255:248] = 8'hFF;
    for (int i = 1; i < 32; i++) r_lit[255-8*i -: 8] = 8'(i);

    $display("[TB] reset and key load");
    @(posedge i_clk); #1;
    checks_on = 1'b1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("reset_rx_ready", 256'(o_rx_ready), 256'(1));
    chk("reset_busy", 256'(o_busy), 256'(0));
    chk("reset_tx_valid", 256'(o_tx_valid), 256'(0));
    chk("reset_tx_data", 256'(o_tx_data), 256'(0));
    chk("reset_core_n", o_core_n, 256'(0));
    @(posedge i_clk); #1;

    send_vec(N_LIT, 1'b0, 1'b1);
    send_vec(D_LIT, 1'b0, 1'b1);
    chk("key_n_literal", o_core_n, N_LIT);
    chk("key_d_literal", o_core_d, D_LIT);

    $display("[TB] first ciphertext, result streaming");
    a_vec = rand256();
    send_vec(a_vec, 1'b0, 1'b0);
    check_start(a_vec);
    finish_core(r_lit, 98);
    receive_bytes(0, r_lit, "stream", fb, lb);
    chk("stream_first_literal", 256'(fb), 256'(8'h01));
    chk("stream_last_literal", 256'(lb), 256'(8'h1F));

    $display("[TB] key reuse with tx back-pressure");
    a_vec = rand256();
    send_vec(a_vec, 1'b1, 1'b0);
    check_start(a_vec);
    chk("reuse_n_literal", o_core_n, N_LIT);
    chk("reuse_d_literal", o_core_d, D_LIT);
    finish_core(r_lit, 98);
    receive_bytes(1, r_lit, "bp", fb, lb);
    chk("bp_first_literal", 256'(fb), 256'(8'h01));
    chk("bp_last_literal", 256'(lb), 256'(8'h1F));

    $display("[TB] reset while waiting on core");
    a_vec = rand256();
    send_vec(a_vec, 1'b0, 1'b0);
    check_start(a_vec);
    i_core_result = r_lit;
    repeat (10) begin
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_core_finished = 1'b1;
    @(posedge i_clk); #1;
    i_core_finished = 1'b0;
    i_tx_ready = 1'b1;
    @(negedge i_clk);
    chk("midrst_rx_ready", 256'(o_rx_ready), 256'(1));
    chk("midrst_busy", 256'(o_busy), 256'(0));
    chk("midrst_core_n", o_core_n, 256'(0));
    chk("midrst_core_d", o_core_d, 256'(0));
    chk("midrst_core_a", o_core_a, 256'(0));
    saw_tx = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_tx_valid) saw_tx = 1'b1;
    end
    chk("midrst_no_tx", 256'(saw_tx), 256'(0));
    @(posedge i_clk); #1;
    i_tx_ready = 1'b0;

    $display("[TB] randomized key and ciphertexts");
    send_vec(rand256(), 1'b1, 1'b0);
    send_vec(rand256(), 1'b1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      a_vec = rand256();
      res   = rand256();
      send_vec(a_vec, 1'b1, 1'b0);
      check_start(a_vec);
      finish_core(res, $urandom_range(1, 40));
      receive_bytes(2, res, "rand", fb, lb);
    end

    checks_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
